caixa_agua_nivel_n: RTL and testbench

Parametrised successor to the three-sensor tank controller. Monitors N level probes (thermometer-coded, bit 0 lowest) through synchronisers and a debounce filter. Runs a fill-valve state machine with hysteresis and latches faults until acknowledged. Drives the valve, alarm, error and "tank usable" outputs for the pump/distribution logic.

---
 rtl/caixa_agua_nivel_n.sv | 215 +++++++++++++++++++++
 tb/tb_caixa_agua_nivel_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/caixa_agua_nivel_n.sv
// caixa_agua_nivel_n: water tank fill controller for N level probes.
// Probes are synchronised, debounced and checked for a thermometer pattern;
// a three-state FSM drives the fill valve with hysteresis and latches faults
// until acknowledged. All outputs are registered from next-state values.
// Optional build macro: CAIXA_TIMEOUT_EN adds a fill timeout of T_MAX cycles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// REPOUSO  | valve closed, waiting for level to drop to NIVEL_LIGA
// ENCHENDO | valve open, filling until every probe is wet
// FALHA    | valve closed, fault latched until reconhece with a valid pattern

module caixa_agua_nivel_n #(
    parameter int N_NIVEIS    = 4,
    parameter int DEBOUNCE    = 4,
    parameter int NIVEL_LIGA  = 1,
    parameter int NIVEL_MEDIO = 2,
    parameter int T_MAX       = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_NIVEIS-1:0]               sensores,
    input  logic                              reconhece,
    output logic                              ve,
    output logic                              erro,
    output logic                              alarme,
    output logic                              caixa,
    output logic [$clog2(N_NIVEIS+1)-1:0]     nivel
);

    localparam int NW = $clog2(N_NIVEIS + 1);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        REPOUSO  = 2'd0,
        ENCHENDO = 2'd1,
        FALHA    = 2'd2
    } estado_t;

    function automatic logic [NW-1:0] f_popcount(input logic [N_NIVEIS-1:0] p);
        logic [NW-1:0] c;
        c = '0;
        for (int i = 0; i < N_NIVEIS; i++) begin
            c = c + NW'(p[i]);
        end
        return c;
    endfunction

    logic [N_NIVEIS-1:0] r_sync1;
    logic [N_NIVEIS-1:0] r_sync2;
    logic [N_NIVEIS-1:0] r_prev;
    logic [1:0]          r_sync_vld;
    logic [CW-1:0]       r_cnt;
    logic [N_NIVEIS-1:0] r_filt;
    logic                r_filt_vld;

    estado_t             r_estado;
    logic [NW-1:0]       r_nivel;
    logic                r_ve;
    logic                r_erro;
    logic                r_alarme;
    logic                r_caixa;

    logic                w_dif;
    logic [CW-1:0]       w_run;
    logic                w_load;
    logic                w_erro_padrao;
    logic [NW-1:0]       w_nivel_nx;
    logic                w_timeout;
    logic                w_falha;
    estado_t             w_estado_nx;
    logic                w_ve_nx;
    logic                w_erro_nx;
    logic                w_alarme_nx;
    logic                w_caixa_nx;

    // Two-flop synchroniser; r_sync_vld marks when r_sync2 holds a real sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync1    <= sensores;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // Length of the current run of identical synchronised patterns, saturating
    always_comb begin
        w_dif  = (r_sync2 != r_prev);
        w_run  = CW'(1);
        if (r_cnt == '0 || w_dif) begin
            w_run = CW'(1);
        end else if (r_cnt == CW'(DEBOUNCE)) begin
            w_run = r_cnt;
        end else begin
            w_run = r_cnt + CW'(1);
        end
        w_load = r_sync_vld[1] && (w_run == CW'(DEBOUNCE));
    end

    // Debounce counter and filtered pattern register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_filt     <= '0;
            r_filt_vld <= 1'b0;
        end else begin
            r_cnt <= r_sync_vld[1] ? w_run : '0;
            if (w_load) begin
                r_filt     <= r_sync2;
                r_filt_vld <= 1'b1;
            end
        end
    end

    // A wet probe above a dry one means a stuck or broken probe
    always_comb begin
        w_erro_padrao = 1'b0;
        for (int i = 1; i < N_NIVEIS; i++) begin
            if (r_filt[i] && !r_filt[i-1]) begin
                w_erro_padrao = 1'b1;
            end
        end
        w_nivel_nx = w_erro_padrao ? r_nivel : f_popcount(r_filt);
    end

`ifdef CAIXA_TIMEOUT_EN
    localparam int TW = $clog2(T_MAX + 1);

    logic [TW-1:0] r_tmr;

    assign w_timeout = (r_estado == ENCHENDO) && (r_tmr == TW'(T_MAX));

    // Fill timer: restarts on entry to ENCHENDO and whenever the level rises
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmr <= '0;
        end else if (r_estado != ENCHENDO || w_estado_nx != ENCHENDO ||
                     w_nivel_nx > r_nivel) begin
            r_tmr <= '0;
        end else if (r_tmr != TW'(T_MAX)) begin
            r_tmr <= r_tmr + TW'(1);
        end
    end
`else
    // No timer in this build; T_MAX has no effect and the term is always 0
    assign w_timeout = (T_MAX < 0);
`endif

    assign w_falha = w_erro_padrao | w_timeout;

    // FSM state register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= REPOUSO;
            r_nivel  <= '0;
            r_ve     <= 1'b0;
            r_erro   <= 1'b0;
            r_alarme <= 1'b1;
            r_caixa  <= 1'b0;
        end else begin
            r_estado <= w_estado_nx;
            r_nivel  <= w_nivel_nx;
            r_ve     <= w_ve_nx;
            r_erro   <= w_erro_nx;
            r_alarme <= w_alarme_nx;
            r_caixa  <= w_caixa_nx;
        end
    end

    // Next state and next output values; FSM waits for the first filtered pattern
    always_comb begin
        w_estado_nx = r_estado;
        if (r_filt_vld) begin
            case (r_estado)
                REPOUSO: begin
                    if (w_falha) begin
                        w_estado_nx = FALHA;
                    end else if (w_nivel_nx <= NW'(NIVEL_LIGA)) begin
                        w_estado_nx = ENCHENDO;
                    end
                end
                ENCHENDO: begin
                    if (w_falha) begin
                        w_estado_nx = FALHA;
                    end else if (w_nivel_nx == NW'(N_NIVEIS)) begin
                        w_estado_nx = REPOUSO;
                    end
                end
                FALHA: begin
                    if (reconhece && !w_erro_padrao) begin
                        w_estado_nx = REPOUSO;
                    end
                end
                default: w_estado_nx = REPOUSO;
            endcase
        end
        w_ve_nx     = (w_estado_nx == ENCHENDO);
        w_erro_nx   = (w_estado_nx == FALHA);
        w_alarme_nx = w_erro_nx | (w_nivel_nx == '0);
        w_caixa_nx  = (w_nivel_nx >= NW'(NIVEL_MEDIO)) & ~w_erro_nx;
    end

    assign ve     = r_ve;
    assign erro   = r_erro;
    assign alarme = r_alarme;
    assign caixa  = r_caixa;
    assign nivel  = r_nivel;

endmodule

// File: tb/tb_caixa_agua_nivel_n.sv
// Bench for caixa_agua_nivel_n: directed probe patterns, a reference model
// built from the behavioural rules, per-cycle output comparison and literal
// spot checks at the interesting points.
`timescale 1ns/1ps

module tb_caixa_agua_nivel_n;

    localparam int N_NIVEIS    = 4;
    localparam int DEBOUNCE    = 4;
    localparam int NIVEL_LIGA  = 1;
    localparam int NIVEL_MEDIO = 2;
    localparam int T_MAX       = 64;
    localparam int NW          = $clog2(N_NIVEIS + 1);

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_FAULT = 2;

    logic                clock;
    logic                reset;
    logic [N_NIVEIS-1:0] sensores;
    logic                reconhece;
    logic                ve;
    logic                erro;
    logic                alarme;
    logic                caixa;
    logic [NW-1:0]       nivel;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    caixa_agua_nivel_n #(
        .N_NIVEIS   (N_NIVEIS),
        .DEBOUNCE   (DEBOUNCE),
        .NIVEL_LIGA (NIVEL_LIGA),
        .NIVEL_MEDIO(NIVEL_MEDIO),
        .T_MAX      (T_MAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sensores (sensores),
        .reconhece(reconhece),
        .ve       (ve),
        .erro     (erro),
        .alarme   (alarme),
        .caixa    (caixa),
        .nivel    (nivel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    int m_q[$];
    int m_filt, m_nivel, m_st, m_lvl, m_nst;
    bit m_fvld, m_pad, m_flt, m_ok;
    bit m_ve, m_erro, m_alarme, m_caixa;
`ifdef CAIXA_TIMEOUT_EN
    int m_tmr;
`endif

    function automatic bit is_thermo(input int p);
        return p == ((1 << $countones(p)) - 1);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_filt = 0; m_nivel = 0; m_st = M_IDLE; m_fvld = 0;
            m_ve = 0; m_erro = 0; m_alarme = 1; m_caixa = 0;
`ifdef CAIXA_TIMEOUT_EN
            m_tmr = 0;
`endif
        end else begin
            m_pad = !is_thermo(m_filt);
            m_lvl = m_pad ? m_nivel : $countones(m_filt);
            m_flt = m_pad;
`ifdef CAIXA_TIMEOUT_EN
            if (m_st == M_FILL && m_tmr == T_MAX) m_flt = 1;
`endif
            m_nst = m_st;
            if (m_fvld) begin
                if (m_st == M_FAULT) begin
                    if (reconhece && !m_pad) m_nst = M_IDLE;
                end else if (m_flt) m_nst = M_FAULT;
                else if (m_st == M_IDLE && m_lvl <= NIVEL_LIGA) m_nst = M_FILL;
                else if (m_st == M_FILL && m_lvl == N_NIVEIS) m_nst = M_IDLE;
            end
`ifdef CAIXA_TIMEOUT_EN
            if (m_st == M_FILL && m_nst == M_FILL && m_lvl <= m_nivel)
                m_tmr = (m_tmr < T_MAX) ? m_tmr + 1 : T_MAX;
            else
                m_tmr = 0;
`endif
            m_ve     = (m_nst == M_FILL);
            m_erro   = (m_nst == M_FAULT);
            m_alarme = m_erro || (m_lvl == 0);
            m_caixa  = (m_lvl >= NIVEL_MEDIO) && !m_erro;
            m_nivel  = m_lvl;
            m_st     = m_nst;
            // pattern accepted once the synchronised samples were equal DEBOUNCE times
            if (m_q.size() >= DEBOUNCE + 1) begin
                m_ok = 1;
                for (int k = 2; k <= DEBOUNCE + 1; k++)
                    if (m_q[m_q.size()-k] != m_q[m_q.size()-2]) m_ok = 0;
                if (m_ok) begin
                    m_filt = m_q[m_q.size()-2];
                    m_fvld = 1;
                end
            end
            m_q.push_back(int'(sensores));
            if (m_q.size() > DEBOUNCE + 2) void'(m_q.pop_front());
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (mon_en) begin
            chk("ve",     int'(ve),     int'(m_ve));
            chk("erro",   int'(erro),   int'(m_erro));
            chk("alarme", int'(alarme), int'(m_alarme));
            chk("caixa",  int'(caixa),  int'(m_caixa));
            chk("nivel",  int'(nivel),  m_nivel);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic hold(input logic [N_NIVEIS-1:0] p, input int n);
        sensores = p;
        step(n);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; sensores = '0; reconhece = 1'b0;
        step(3);
        mon_en = 1'b1;
        chk("rst_ve",     int'(ve),     0);
        chk("rst_erro",   int'(erro),   0);
        chk("rst_alarme", int'(alarme), 1);
        chk("rst_caixa",  int'(caixa),  0);
        chk("rst_nivel",  int'(nivel),  0);

        // 1: release, valve opens once the first filtered pattern reaches the FSM
        reset = 1'b0;
        step(6);
        chk("t1_ve_early", int'(ve), 0);
        step(1);
        chk("t1_ve_open", int'(ve), 1);
        chk("t1_nivel",   int'(nivel), 0);
        step(1);
        chk("t1_ve_next", int'(ve), 1);

        // 2: fill ramp
        hold(4'b0001, 10);
        chk("t2_n1_nivel",  int'(nivel),  1);
        chk("t2_n1_alarme", int'(alarme), 0);
        chk("t2_n1_caixa",  int'(caixa),  0);
        hold(4'b0011, 10);
        chk("t2_n2_caixa", int'(caixa), 1);
        chk("t2_n2_ve",    int'(ve),    1);
        hold(4'b0111, 10);
        chk("t2_n3_ve", int'(ve), 1);
        hold(4'b1111, 10);
        chk("t2_n4_nivel", int'(nivel), 4);
        chk("t2_n4_ve",    int'(ve),    0);

        // 3: drain with hysteresis
        hold(4'b0111, 10);
        chk("t3_n3_ve", int'(ve), 0);
        hold(4'b0011, 10);
        chk("t3_n2_ve", int'(ve), 0);
        hold(4'b0001, 6);
        chk("t3_ve_before", int'(ve), 0);
        step(1);
        chk("t3_ve_at_d3", int'(ve), 1);
        hold(4'b0011, 10);

        // 4: short glitch rejected by the debounce
        hold(4'b0111, 3);
        hold(4'b0011, 10);
        chk("t4_nivel", int'(nivel), 2);
        chk("t4_ve",    int'(ve),    1);

        // 5: invalid pattern, acknowledge rules
        hold(4'b0101, 10);
        chk("t5_erro",   int'(erro),   1);
        chk("t5_alarme", int'(alarme), 1);
        chk("t5_ve",     int'(ve),     0);
        chk("t5_caixa",  int'(caixa),  0);
        chk("t5_nivel",  int'(nivel),  2);
        reconhece = 1'b1;
        step(3);
        chk("t5_ack_bad", int'(erro), 1);
        reconhece = 1'b0;
        hold(4'b0011, 10);
        chk("t5_no_ack", int'(erro), 1);
        reconhece = 1'b1;
        step(2);
        chk("t5_ack_erro",  int'(erro),  0);
        chk("t5_ack_ve",    int'(ve),    0);
        chk("t5_ack_caixa", int'(caixa), 1);

        // reconhece left high outside FALHA; valve still opens at low level
        hold(4'b0001, 7);
        chk("t5_ack_high_ve", int'(ve), 1);

        // reset mid-fill closes the valve on the same edge
        reset = 1'b1;
        step(1);
        chk("mid_rst_ve",     int'(ve),     0);
        chk("mid_rst_alarme", int'(alarme), 1);
        reset = 1'b0;
        reconhece = 1'b0;
        step(7);
        chk("after_rst_ve",    int'(ve),    1);
        chk("after_rst_nivel", int'(nivel), 1);

        // 6: long fill at a constant level
        step(80);
`ifdef CAIXA_TIMEOUT_EN
        chk("t6_erro", int'(erro), 1);
        chk("t6_ve",   int'(ve),   0);
`else
        chk("t6_erro", int'(erro), 0);
        chk("t6_ve",   int'(ve),   1);
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
